// File: rtl/sprite_blit.sv
// sprite_blit: walks a 1-bpp sprite held in an external registered ROM row by
// row and emits one (x, y) coordinate per set pixel on a valid/ready stream.
// Optional feature macro: SPRITE_BLIT_ZSKIP_EN (all-zero rows skip SCAN).
module sprite_blit #(
    parameter int SPR_W   = 59,
    parameter int SPR_H   = 66,
    parameter int ROW_AW  = 7,
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic               flip_h,
    output logic               busy,
    output logic               done,
    output logic [ROW_AW-1:0]  rom_addr,
    input  logic [SPR_W-1:0]   rom_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y
);
    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam logic [CW-1:0]     COL_LAST = CW'(SPR_W - 1);
    localparam logic [ROW_AW-1:0] ROW_LAST = ROW_AW'(SPR_H - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SCAN, DONE} state_t;

    state_t             state_q, state_d;
    logic [ROW_AW-1:0]  row_q, row_d;
    logic [CW-1:0]      col_q, col_d;
    logic [SPR_W-1:0]   data_q, data_d;
    logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d;
    logic               flip_q, flip_d;
    logic [CW-1:0]      bit_idx;
    logic               cur_bit;

    // Pixel under the scan cursor; bit SPR_W-1 is leftmost unless mirrored.
    always_comb begin
        bit_idx = flip_q ? col_q : (COL_LAST - col_q);
        cur_bit = data_q[bit_idx];
    end

    // State register and datapath flops; rst aborts any blit in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            data_q  <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            flip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            data_q  <= data_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            flip_q  <= flip_d;
        end
    end

    // Next-state logic and stream outputs.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        data_d    = data_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        flip_d    = flip_q;
        pix_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x0_d    = x0;
                    y0_d    = y0;
                    flip_d  = flip_h;
                    row_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                data_d  = rom_data;
                col_d   = '0;
                state_d = SCAN;
`ifdef SPRITE_BLIT_ZSKIP_EN
                // Blank row: nothing to emit, go straight to the next fetch.
                if (rom_data == '0) begin
                    if (row_q == ROW_LAST) begin
                        state_d = DONE;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = FETCH;
                    end
                end
`endif
            end
            SCAN: begin
                pix_valid = cur_bit;
                // Clear bits advance freely; set bits wait for the handshake.
                if (!cur_bit || pix_ready) begin
                    if (col_q == COL_LAST) begin
                        if (row_q == ROW_LAST) begin
                            state_d = DONE;
                        end else begin
                            row_d   = row_q + 1'b1;
                            state_d = FETCH;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Coordinates are zeroed when nothing is offered so idle/reset reads 0.
    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        rom_addr = row_q;
        pix_x    = pix_valid ? (x0_q + COORD_W'(col_q)) : '0;
        pix_y    = pix_valid ? (y0_q + COORD_W'(row_q)) : '0;
    end
endmodule

// File: tb/tb_sprite_blit.sv
// Directed bench for sprite_blit: registered ROM model, pixel capture on the
// handshake, stall-stability monitor, cycle counts to done.
module tb_sprite_blit;
    localparam int SPR_W = 59, SPR_H = 66, ROW_AW = 7, COORD_W = 10;
`ifdef SPRITE_BLIT_ZSKIP_EN
    localparam int ZERO_CYC = 132;
`else
    localparam int ZERO_CYC = 4026;
`endif

    logic               clk = 1'b0;
    logic               rst, start, flip_h, pix_ready;
    logic [COORD_W-1:0] x0, y0, pix_x, pix_y;
    logic               busy, done, pix_valid;
    logic [ROW_AW-1:0]  rom_addr;
    logic [SPR_W-1:0]   rom_q;
    logic [SPR_W-1:0]   rom [0:(1<<ROW_AW)-1];

    int n_chk = 0, n_bad = 0;
    int stab_err = 0, done_cnt = 0;
    logic ready_fixed = 1'b1, rand_mode = 1'b0;
    logic [19:0] pq[$];
    logic [19:0] ex[$];
    logic pv = 1'b0, pr = 1'b0, prst = 1'b0;
    logic [COORD_W-1:0] px_prev = '0, py_prev = '0;
    int cyc;
    logic gd;

    sprite_blit #(.SPR_W(SPR_W), .SPR_H(SPR_H), .ROW_AW(ROW_AW), .COORD_W(COORD_W)) dut (
        .clk(clk), .rst(rst), .start(start), .x0(x0), .y0(y0), .flip_h(flip_h),
        .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_q),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y)
    );

    always #5 clk = ~clk;

    // ROM with one cycle of read latency.
    always @(posedge clk) rom_q <= rom[rom_addr];

    // Consumer ready: fixed or random, changed just after each edge.
    always @(posedge clk) begin
        #1;
        pix_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    // Capture handshakes, count done pulses, watch stalled offers.
    always @(negedge clk) begin
        if (pix_valid && pix_ready) pq.push_back({pix_x, pix_y});
        if (done) done_cnt++;
        if (pv && !pr && !prst)
            if (!(pix_valid && pix_x == px_prev && pix_y == py_prev)) stab_err++;
        pv = pix_valid; pr = pix_ready; prst = rst;
        px_prev = pix_x; py_prev = pix_y;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic rom_clear();
        for (int i = 0; i < (1 << ROW_AW); i++) rom[i] = '0;
    endtask

    task automatic set_px(input int r, input int c);
        rom[r][SPR_W-1-c] = 1'b1;
    endtask

    function automatic logic [19:0] pk(input int x, input int y);
        logic [9:0] xx, yy;
        xx = 10'(x); yy = 10'(y);
        return {xx, yy};
    endfunction

    task automatic check_seq(input string tag);
        chk({tag, "_count"}, pq.size(), ex.size());
        for (int i = 0; i < ex.size() && i < pq.size(); i++)
            chk({tag, "_pix"}, {12'h0, pq[i]}, {12'h0, ex[i]});
    endtask

    // Issue a start and count cycles from busy rising until done.
    task automatic blit(input int x, input int y, input logic f,
                        output int c, output logic got_done);
        pq.delete();
        @(posedge clk); #1;
        start = 1'b1; x0 = 10'(x); y0 = 10'(y); flip_h = f;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        chk("addr_after_start", rom_addr, 0);
        c = 0;
        while (!done && c < 20000) begin
            @(posedge clk); #1;
            c++;
        end
        got_done = done;
        @(posedge clk); #1;
        chk("busy_after_done", busy, 1'b0);
        chk("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; x0 = '0; y0 = '0; flip_h = 1'b0; pix_ready = 1'b1;
        rom_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", pix_valid, 0);
        chk("rst_x", pix_x, 0);
        chk("rst_y", pix_y, 0);
        chk("rst_addr", rom_addr, 0);
        rst = 1'b0;

        // Ring-like pattern: row 0 cols 26..32, row 17 cols 0,1,57,58.
        rom_clear();
        for (int c = 26; c <= 32; c++) set_px(0, c);
        set_px(17, 0); set_px(17, 1); set_px(17, 57); set_px(17, 58);
        ex.delete();
        for (int c = 126; c <= 132; c++) ex.push_back(pk(c, 50));
        ex.push_back(pk(100, 67)); ex.push_back(pk(101, 67));
        ex.push_back(pk(157, 67)); ex.push_back(pk(158, 67));
        blit(100, 50, 1'b0, cyc, gd);
        chk("ring_done", gd, 1'b1);
        chk("ring_cycles", cyc, 4026);
        check_seq("ring");

        // Same sprite under random back-pressure.
        rand_mode = 1'b1;
        stab_err = 0;
        blit(100, 50, 1'b0, cyc, gd);
        rand_mode = 1'b0;
        chk("rand_done", gd, 1'b1);
        check_seq("rand");
        chk("rand_stable", stab_err, 0);

        // Single MSB in row 0, plain and mirrored.
        rom_clear();
        rom[0][SPR_W-1] = 1'b1;
        ex.delete(); ex.push_back(pk(200, 10));
        blit(200, 10, 1'b0, cyc, gd);
        check_seq("msb");
        ex.delete(); ex.push_back(pk(258, 10));
        blit(200, 10, 1'b1, cyc, gd);
        check_seq("msb_flip");

        // X wraps modulo 1024.
        rom_clear();
        set_px(0, 30);
        ex.delete(); ex.push_back(pk(6, 0));
        blit(1000, 0, 1'b0, cyc, gd);
        check_seq("wrap");

        // Reset while scanning row 5, then a clean restart.
        rom_clear();
        set_px(0, 3); set_px(5, 10);
        @(posedge clk); #1;
        start = 1'b1; x0 = 10'd20; y0 = 10'd30; flip_h = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!(pix_valid && pix_y == 10'd35) && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("row5_reached", pix_valid && pix_y == 10'd35, 1'b1);
        begin
            int dc;
            dc = done_cnt;
            rst = 1'b1;
            @(posedge clk); #1;
            chk("abort_busy", busy, 0);
            chk("abort_valid", pix_valid, 0);
            rst = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            chk("abort_no_done", done_cnt, dc);
        end
        ex.delete(); ex.push_back(pk(23, 30)); ex.push_back(pk(30, 35));
        blit(20, 30, 1'b0, cyc, gd);
        chk("restart_done", gd, 1'b1);
        check_seq("restart");

        // All-zero sprite.
        rom_clear();
        ex.delete();
        blit(0, 0, 1'b0, cyc, gd);
        chk("zero_done", gd, 1'b1);
        chk("zero_cycles", cyc, ZERO_CYC);
        check_seq("zero");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
